// File: rtl/sha3_ctrl_pkg.sv
// Shared definitions for the multi-block SHA-3 control slice.
//   - sha3_state_e : controller state encoding (3 bits)
//   - SHA3_NUM_ROUNDS : default Keccak-f round count
//   - rnd_cnt_w()  : width of a counter that indexes NUM_ROUNDS rounds
package sha3_ctrl_pkg;

  localparam int SHA3_NUM_ROUNDS = 24;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PAD  = 3'd2,
    PERM = 3'd3,
    SQZ  = 3'd4,
    DONE = 3'd5
  } sha3_state_e;

  // A single-round permutation still needs a 1-bit index.
  function automatic int rnd_cnt_w(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/sha3_round_cnt.sv
// Keccak round-group counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (abort)
//   en       : advance by STEP this cycle
//   cnt      : index of the first round executed this cycle
//   term     : last round group of the permutation is executing
module sha3_round_cnt
  import sha3_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = SHA3_NUM_ROUNDS,
  parameter int STEP       = 1,
  localparam int W         = rnd_cnt_w(NUM_ROUNDS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);

  localparam logic [W-1:0] STEP_V = W'(STEP);
  localparam logic [W-1:0] LAST_V = W'(NUM_ROUNDS - STEP);

  // Round counter: wraps to zero after the last round group.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= {W{1'b0}};
    end else if (en) begin
      if (term) begin
        cnt <= {W{1'b0}};
      end else begin
        cnt <= cnt + STEP_V;
      end
    end
  end

  // Gated by en so an idle counter at zero never looks terminal.
  assign term = en && (cnt == LAST_V);

endmodule

// File: rtl/sha3_ctrl_multi.sv
// Multi-block SHA-3 / SHAKE control FSM.
// Sequences absorb (LOAD), padding (PAD), the Keccak-f permutation (PERM)
// and digest hand-off (DONE). Define SHA3_SQUEEZE_EN to add the SQZ state
// for additional output blocks.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, abort      : begin message (IDLE only) / return to IDLE
//   last, buff_full   : final word marker / full rate block available
//   digest_ack        : consumer took the digest
//   squeeze_req       : ask for another output block (with SHA3_SQUEEZE_EN)
//   in_ready, pad_en  : accepting words / padder appends pad10*1
//   en_vsx            : state XOR/load strobe, first cycle of an absorb PERM
//   first_blk, nxt_block : qualifies en_vsx as first or later block
//   en_counter, round_idx : permutation active / first round this cycle
//   digest_valid, busy, blk_cnt : output valid / not idle / blocks absorbed
module sha3_ctrl_multi
  import sha3_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS       = SHA3_NUM_ROUNDS,
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int BLK_CNT_W        = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                last,
  input  logic                                buff_full,
  input  logic                                digest_ack,
  input  logic                                squeeze_req,
  output logic                                in_ready,
  output logic                                pad_en,
  output logic                                en_vsx,
  output logic                                first_blk,
  output logic                                nxt_block,
  output logic                                en_counter,
  output logic [rnd_cnt_w(NUM_ROUNDS)-1:0]    round_idx,
  output logic                                digest_valid,
  output logic                                busy,
  output logic [BLK_CNT_W-1:0]                blk_cnt
);

  if ((NUM_ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must divide NUM_ROUNDS");
  end

  localparam logic [BLK_CNT_W-1:0] BLK_MAX = {BLK_CNT_W{1'b1}};
  localparam logic [BLK_CNT_W-1:0] BLK_ONE = BLK_CNT_W'(1'b1);

  sha3_state_e state_r, state_nxt_s;
  logic        first_r, final_r;
  logic        cnt_en_s, term_s;

`ifndef SHA3_SQUEEZE_EN
  logic unused_sqz_s;
  assign unused_sqz_s = squeeze_req;
`endif

  assign cnt_en_s = (state_r == PERM) || (state_r == SQZ);

  sha3_round_cnt #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .STEP       (ROUNDS_PER_CYCLE)
  ) u_round_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (abort),
    .en   (cnt_en_s),
    .cnt  (round_idx),
    .term (term_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nxt_s = state_r;
    if (abort) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) state_nxt_s = LOAD;
          else       state_nxt_s = IDLE;
        end
        LOAD: begin
          if (buff_full) state_nxt_s = PERM;
          else if (last) state_nxt_s = PAD;
          else           state_nxt_s = LOAD;
        end
        PAD: state_nxt_s = PERM;
        PERM: begin
          if (term_s) state_nxt_s = final_r ? DONE : LOAD;
          else        state_nxt_s = PERM;
        end
`ifdef SHA3_SQUEEZE_EN
        SQZ: begin
          if (term_s) state_nxt_s = DONE;
          else        state_nxt_s = SQZ;
        end
        DONE: begin
          if (digest_ack) state_nxt_s = squeeze_req ? SQZ : IDLE;
          else            state_nxt_s = DONE;
        end
`else
        SQZ: state_nxt_s = IDLE;
        DONE: begin
          if (digest_ack) state_nxt_s = IDLE;
          else            state_nxt_s = DONE;
        end
`endif
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Message bookkeeping: first/final block flags and absorbed-block count.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      first_r <= 1'b1;
      final_r <= 1'b0;
      blk_cnt <= {BLK_CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            first_r <= 1'b1;
            final_r <= 1'b0;
            blk_cnt <= {BLK_CNT_W{1'b0}};
          end
        end
        LOAD: begin
          if (last) final_r <= 1'b1;
        end
        PERM: begin
          if (term_s) begin
            first_r <= 1'b0;
            if (blk_cnt != BLK_MAX) blk_cnt <= blk_cnt + BLK_ONE;
          end
        end
        default: begin
          first_r <= first_r;
        end
      endcase
    end
  end

  // Outputs registered from the state being entered, so each output equals
  // the decode of the current state; the absorb strobes fire only on entry
  // to PERM (never on SQZ).
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready     <= 1'b0;
      pad_en       <= 1'b0;
      en_vsx       <= 1'b0;
      first_blk    <= 1'b0;
      nxt_block    <= 1'b0;
      en_counter   <= 1'b0;
      digest_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      in_ready     <= (state_nxt_s == LOAD);
      pad_en       <= (state_nxt_s == PAD);
      en_counter   <= (state_nxt_s == PERM) || (state_nxt_s == SQZ);
      digest_valid <= (state_nxt_s == DONE);
      busy         <= (state_nxt_s != IDLE);
      en_vsx       <= (state_nxt_s == PERM) && (state_r != PERM);
      first_blk    <= (state_nxt_s == PERM) && (state_r != PERM) && first_r;
      nxt_block    <= (state_nxt_s == PERM) && (state_r != PERM) && !first_r;
    end
  end

endmodule

// File: tb/tb_sha3_ctrl_multi.sv
module tb_sha3_ctrl_multi;

  localparam int NR = 24;

  // stimulus bits: {start, abort, last, buff_full, digest_ack, squeeze_req}
  localparam logic [5:0] S_START = 6'b100000;
  localparam logic [5:0] S_ABORT = 6'b010000;
  localparam logic [5:0] S_LAST  = 6'b001000;
  localparam logic [5:0] S_BF    = 6'b000100;
  localparam logic [5:0] S_ACK   = 6'b000010;
  localparam logic [5:0] S_SQ    = 6'b000001;
  // don't-care masks per situation (bits the design must ignore there)
  localparam logic [5:0] M_LOAD  = 6'b100011;
  localparam logic [5:0] M_ANY   = 6'b101111;
  localparam logic [5:0] M_DONE  = 6'b101101;
  localparam logic [5:0] M_ACK   = 6'b101100;
  localparam logic [5:0] M_IDLE  = 6'b001111;

  // expected flags: {in_ready,pad_en,en_vsx,first_blk,nxt_block,en_counter,digest_valid,busy}
  localparam logic [7:0] F_IDLE = 8'b0000_0000;
  localparam logic [7:0] F_LOAD = 8'b1000_0001;
  localparam logic [7:0] F_PAD  = 8'b0100_0001;
  localparam logic [7:0] F_SQZ  = 8'b0000_0101;
  localparam logic [7:0] F_DONE = 8'b0000_0011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] stim0 = 6'd0;
  logic [5:0] stim1 = 6'd0;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wire a_in_ready, a_pad_en, a_en_vsx, a_first_blk, a_nxt_block, a_en_counter, a_digest_valid, a_busy;
  wire b_in_ready, b_pad_en, b_en_vsx, b_first_blk, b_nxt_block, b_en_counter, b_digest_valid, b_busy;
  wire [4:0]  a_round_idx, b_round_idx;
  wire [15:0] a_blk_cnt;
  wire [1:0]  b_blk_cnt;

  sha3_ctrl_multi #(.NUM_ROUNDS(NR), .ROUNDS_PER_CYCLE(1), .BLK_CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .start(stim0[5]), .abort(stim0[4]), .last(stim0[3]),
    .buff_full(stim0[2]), .digest_ack(stim0[1]), .squeeze_req(stim0[0]),
    .in_ready(a_in_ready), .pad_en(a_pad_en), .en_vsx(a_en_vsx), .first_blk(a_first_blk),
    .nxt_block(a_nxt_block), .en_counter(a_en_counter), .round_idx(a_round_idx),
    .digest_valid(a_digest_valid), .busy(a_busy), .blk_cnt(a_blk_cnt));

  sha3_ctrl_multi #(.NUM_ROUNDS(NR), .ROUNDS_PER_CYCLE(2), .BLK_CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(stim1[5]), .abort(stim1[4]), .last(stim1[3]),
    .buff_full(stim1[2]), .digest_ack(stim1[1]), .squeeze_req(stim1[0]),
    .in_ready(b_in_ready), .pad_en(b_pad_en), .en_vsx(b_en_vsx), .first_blk(b_first_blk),
    .nxt_block(b_nxt_block), .en_counter(b_en_counter), .round_idx(b_round_idx),
    .digest_valid(b_digest_valid), .busy(b_busy), .blk_cnt(b_blk_cnt));

  function automatic int rpc(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int bmax(input int d);
    return (d == 0) ? 65535 : 3;
  endfunction

  function automatic int bsat(input int d, input int n);
    return (n > bmax(d)) ? bmax(d) : n;
  endfunction

  function automatic logic [5:0] nz(input logic [5:0] mask);
    return 6'($urandom) & mask;
  endfunction

  function automatic logic [7:0] perm_flags(input int k, input int i);
    return {1'b0, 1'b0, (k == 0), (k == 0 && i == 0), (k == 0 && i > 0), 1'b1, 1'b0, 1'b1};
  endfunction

  function automatic logic [7:0] obs_flags(input int d);
    if (d == 0)
      return {a_in_ready, a_pad_en, a_en_vsx, a_first_blk, a_nxt_block, a_en_counter, a_digest_valid, a_busy};
    else
      return {b_in_ready, b_pad_en, b_en_vsx, b_first_blk, b_nxt_block, b_en_counter, b_digest_valid, b_busy};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input int d, input string tag, input logic [7:0] ef, input int er, input int eb);
    logic [31:0] ob, orx;
    ob  = (d == 0) ? 32'(a_blk_cnt) : 32'(b_blk_cnt);
    orx = (d == 0) ? 32'(a_round_idx) : 32'(b_round_idx);
    check_val($sformatf("%s.d%0d.flags", tag, d), 32'(obs_flags(d)), 32'(ef));
    check_val($sformatf("%s.d%0d.round_idx", tag, d), orx, 32'(er));
    check_val($sformatf("%s.d%0d.blk_cnt", tag, d), ob, 32'(eb));
  endtask

  // Apply one input vector for the coming edge, then sample just after it.
  task automatic step(input int d, input logic [5:0] v);
    if (d == 0) stim0 = v;
    else        stim1 = v;
    @(posedge clk);
    #1;
  endtask

  // One message of nblk blocks; the final block is partial (PAD) or full+last.
  // abort_k >= 0 aborts in permutation cycle abort_k of the first block.
  task automatic run_msg(input int d, input int nblk, input bit partial, input int nsq, input int abort_k);
    int  plen, hold, sq;
    bit  aborted, fin;
    plen    = NR / rpc(d);
    aborted = 1'b0;
    hold    = bsat(d, nblk);
    step(d, S_START | nz(M_IDLE));
    for (int i = 0; i < nblk && !aborted; i++) begin
      chk_state(d, "load", F_LOAD, 0, bsat(d, i));
      repeat ($urandom_range(0, 3)) begin
        step(d, nz(M_LOAD));
        chk_state(d, "wait", F_LOAD, 0, bsat(d, i));
      end
      fin = (i == nblk - 1);
      if (fin && partial) begin
        step(d, S_LAST | nz(M_LOAD));
        chk_state(d, "pad", F_PAD, 0, bsat(d, i));
        step(d, nz(M_ANY));
      end else begin
        step(d, S_BF | (fin ? S_LAST : 6'd0) | nz(M_LOAD));
      end
      for (int k = 0; k < plen && !aborted; k++) begin
        chk_state(d, "perm", perm_flags(k, i), k * rpc(d), bsat(d, i));
        if (i == 0 && k == abort_k) begin
          step(d, S_ABORT);
          chk_state(d, "abort", F_IDLE, 0, 0);
          aborted = 1'b1;
          hold    = 0;
        end else begin
          step(d, nz(M_ANY));
        end
      end
    end
    sq  = 0;
    fin = aborted;
    while (!fin) begin
      chk_state(d, "done", F_DONE, 0, hold);
      repeat ($urandom_range(0, 3)) begin
        step(d, nz(M_DONE));
        chk_state(d, "hold", F_DONE, 0, hold);
      end
      if (sq < nsq) begin
        sq++;
        step(d, S_ACK | S_SQ | nz(M_ACK));
`ifdef SHA3_SQUEEZE_EN
        for (int k = 0; k < plen; k++) begin
          chk_state(d, "sqz", F_SQZ, k * rpc(d), hold);
          step(d, nz(M_ANY));
        end
`else
        chk_state(d, "ack_sq", F_IDLE, 0, hold);
        fin = 1'b1;
`endif
      end else begin
        step(d, S_ACK | nz(M_ACK));
        chk_state(d, "ack", F_IDLE, 0, hold);
        fin = 1'b1;
      end
    end
    repeat ($urandom_range(1, 3)) begin
      step(d, nz(M_IDLE));
      chk_state(d, "idle", F_IDLE, 0, hold);
    end
    if (d == 0) stim0 = 6'd0;
    else        stim1 = 6'd0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk_state(d, "reset", F_IDLE, 0, 0);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      run_msg(d, 1, 1'b1, 0, -1);
      run_msg(d, 3, 1'b0, 0, -1);
      run_msg(d, 1, 1'b1, 0, 10);
      run_msg(d, 1, 1'b1, 0, -1);
      run_msg(d, 2, 1'b1, 2, -1);
      run_msg(d, 5, 1'b0, 1, -1);
      for (int r = 0; r < 10; r++) begin
        int nb, pt, ns, ak;
        nb = $urandom_range(1, 5);
        pt = $urandom_range(0, 1);
        ns = $urandom_range(0, 2);
        ak = ($urandom_range(0, 4) == 0) ? $urandom_range(0, NR / rpc(d) - 1) : -1;
        run_msg(d, nb, pt[0], ns, ak);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
